// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device transmitter. Sends one command byte to a
//            keyboard using the standard clock-inhibit / request-to-send
//            handshake. Serialises data LSB first, then odd parity and stop.
//            The device's acknowledge bit is then collected.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   INHIBIT_CYCLES : clock-low hold before request-to-send (cycles)
//   TIMEOUT_CYCLES : max cycles from clock release to end of transfer
// Ports
//   vga_clk        : single clock, rising edge
//   reset_n        : synchronous, active-low reset
//   tx_data[7:0]   : command byte, latched on acceptance
//   tx_valid       : request, accepted when tx_ready is high
//   tx_ready       : high only while idle
//   tx_done        : one-cycle pulse on successful completion
//   tx_err         : one-cycle pulse on timeout (or bad ack, see below)
//   ps2_clk/data   : raw asynchronous pad levels
//   ps2_clk_oe     : 1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe    : 1 = pull PS/2 data low, 0 = release
// Configuration
//   PS2_TX_ACK_CHECK_EN : when defined, an ack bit sampled high gives tx_err
//                         instead of tx_done; otherwise the ack is ignored.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // One counter serves both the inhibit hold and the transfer timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_BITS      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            data_meta_q, data_sync_q;
  logic            tx_ready_q, tx_done_q, tx_err_q;
  logic            clk_oe_q, data_oe_q;
`ifdef PS2_TX_ACK_CHECK_EN
  logic            ack_q;
`endif

  logic            clk_fall;
  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      // Synchronisers reset to the idle-high bus level so no false edge
      // is seen when reset is released.
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q       <= 1'b0;
`endif
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            shift_q    <= tx_data;
            parity_q   <= ~^tx_data;
            cnt_q      <= '0;
            clk_oe_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cnt_q == C_INH_LAST) begin
            cnt_q     <= '0;
            data_oe_q <= 1'b1;   // start bit, clock still held low
            state_q   <= S_RTS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RTS: begin
          clk_oe_q  <= 1'b0;
          cnt_q     <= '0;       // timeout measured from clock release
          bit_cnt_q <= '0;
          state_q   <= S_BITS;
        end

        S_BITS, S_ACK, S_WAIT_IDLE: begin
          if (cnt_q == C_TO_LAST) begin
            tx_err_q   <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (state_q == S_BITS) begin
              if (clk_fall) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'd9) begin
                  data_oe_q <= 1'b0;                 // stop bit: release
                  state_q   <= S_ACK;
                end else if (bit_cnt_q == 4'd8) begin
                  data_oe_q <= ~parity_q;
                end else begin
                  data_oe_q <= ~shift_q[bit_cnt_q[2:0]];
                end
              end
            end else if (state_q == S_ACK) begin
              if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                ack_q <= data_sync_q;
`endif
                state_q <= S_WAIT_IDLE;
              end
            end else begin
              if (clk_sync_q && data_sync_q) begin
`ifdef PS2_TX_ACK_CHECK_EN
                if (ack_q) tx_err_q  <= 1'b1;
                else       tx_done_q <= 1'b1;
`else
                tx_done_q <= 1'b1;
`endif
                tx_ready_q <= 1'b1;
                cnt_q      <= '0;
                state_q    <= S_IDLE;
              end
            end
          end
        end

        default: begin
          clk_oe_q   <= 1'b0;
          data_oe_q  <= 1'b0;
          tx_ready_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx. A keyboard model drives the
//            open-drain PS/2 lines and collects the transmitted frame. Expected
//            frames and completion results are queued when a request is issued
//            and popped by the device model / completion monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 2500;   // default inhibit hold
  localparam int TO  = 2000;   // shortened timeout keeps the run short
  localparam int H   = 20;     // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk, ps2_data;

  // Open-drain bus with pull-ups.
  assign ps2_clk  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #20 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int tests = 0;
  int fails = 0;

  logic [9:0] exp_bits_q[$];   // {stop, parity, data}
  bit         exp_res_q[$];    // 0 = tx_done expected, 1 = tx_err expected

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Completion monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        tests++;
        if (tx_done && tx_err) begin
          fails++;
          $display("FAIL done_err_both: got done=1 err=1 expected exactly one");
        end else if (exp_res_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", tx_done, tx_err);
        end else begin
          bit e;
          e = exp_res_q.pop_front();
          if (tx_err !== e) begin
            fails++;
            $display("FAIL completion: got err=%0b expected err=%0b", tx_err, e);
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #8_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts clock-only hold cycles, then clock+data cycles, returning on the
  // first cycle the clock is released.
  task automatic measure_handshake(output int inh, output int rts);
    inh = 0;
    rts = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 10000) begin
      inh++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && rts < 100) begin
      rts++;
      @(negedge clk);
    end
  endtask

  // Keyboard model: waits for request-to-send, clocks n_edges falling edges.
  // A full frame samples 10 bits on rising edges and drives ack before edge 11.
  // A partial frame returns with the clock still held low.
  task automatic dev_frame(input int n_edges, input bit ack_high);
    int         w;
    logic [9:0] got;
    logic [9:0] exp;
    got = '0;
    w   = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && w < 10000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10000) begin
      tests++;
      fails++;
      $display("FAIL rts_wait: got no request-to-send expected one");
      return;
    end
    repeat (10) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (e == n_edges && n_edges < 11) return;
      dev_clk_low = 1'b0;
      if (e <= 10) got[e-1] = ps2_data;
      if (e == 10 && !ack_high) dev_data_low = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
    if (n_edges == 11) begin
      if (exp_bits_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_bits: got %0h expected no frame", got);
      end else begin
        exp = exp_bits_q.pop_front();
        check("frame_bits", {22'd0, got}, {22'd0, exp});
      end
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_res_q.size() != 0 && w < 2 * TO) begin
      @(negedge clk);
      w++;
    end
    if (exp_res_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", exp_res_q.size());
      exp_res_q.delete();
    end
    repeat (50) @(negedge clk);
  endtask

  // Directed frames: data byte, hand-computed odd parity, ack level.
  logic [7:0] vec_d  [4] = '{8'hED, 8'hF4, 8'h00, 8'hFF};
  logic       vec_p  [4] = '{1'b1,  1'b0,  1'b1,  1'b1};
  bit         vec_ah [4] = '{1'b0,  1'b0,  1'b0,  1'b1};

  initial begin
    int inh, rts, cnt;

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   {31'd0, tx_ready},    32'd1);
    check("rst_done",    {31'd0, tx_done},     32'd0);
    check("rst_err",     {31'd0, tx_err},      32'd0);
    check("rst_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Normal frames, including the ack-high case.
    for (int i = 0; i < 4; i++) begin
      exp_bits_q.push_back({1'b1, vec_p[i], vec_d[i]});
`ifdef PS2_TX_ACK_CHECK_EN
      exp_res_q.push_back(vec_ah[i]);
`else
      exp_res_q.push_back(1'b0);
`endif
      send(vec_d[i]);
      check("busy_ready", {31'd0, tx_ready}, 32'd0);
      measure_handshake(inh, rts);
      check("inhibit_len", inh, INH);
      check("rts_len",     rts, 1);
      dev_frame(11, vec_ah[i]);
      wait_drain();
    end

    // Second request during a frame is ignored; tx_data change has no effect.
    exp_bits_q.push_back({1'b1, 1'b1, 8'hED});
    exp_res_q.push_back(1'b0);
    send(8'hED);
    repeat (5) @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(11, 1'b0);
    wait_drain();

    // Device never clocks: timeout measured from clock release.
    exp_res_q.push_back(1'b1);
    send(8'h3C);
    measure_handshake(inh, rts);
    cnt = 0;
    while (!tx_err && cnt < 4 * TO) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_len",     cnt, TO);
    check("to_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
    check("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("to_ready",   {31'd0, tx_ready},    32'd1);
    wait_drain();

    // Reset after edge 4: lines released, no completion pulse.
    send(8'hED);
    dev_frame(4, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
    check("rstmid_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);

    // New request after the abort completes normally.
    exp_bits_q.push_back({1'b1, 1'b0, 8'hF4});
    exp_res_q.push_back(1'b0);
    send(8'hF4);
    measure_handshake(inh, rts);
    check("post_rst_inhibit", inh, INH);
    dev_frame(11, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
